// File: rtl/mips_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle mips core: gates mips.enable,
// takes host debug commands, holds one PC breakpoint and counts executed instructions.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HALTED | core frozen, waiting for a host command
// ST_RUN    | free running until HALT or breakpoint
// ST_STEP   | exactly one instruction executes, then back to halted
// ST_RUN_N  | runs run_cnt instructions, stops early on breakpoint
module mips_run_ctrl #(
    parameter int wordsize = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [2:0]          cmd_op_i,
    input  logic [wordsize-1:0] cmd_arg_i,
    input  logic [wordsize-1:0] pc_i,
    output logic                enable_o,
    output logic                halted_o,
    output logic                bp_hit_o,
    output logic [wordsize-1:0] instr_count_o
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_RUN_N  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_HALT    = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_RUN_N   = 3'd4;
    localparam logic [2:0] OP_SET_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_BP  = 3'd6;
    localparam logic [2:0] OP_CLR_CNT = 3'd7;

    state_t              state_q, state_d;
    logic                bp_en_q, bp_en_d;
    logic [wordsize-1:0] bp_addr_q, bp_addr_d;
    logic [wordsize-1:0] run_cnt_q, run_cnt_d;
    logic                skip_q, skip_d;
    logic                bp_hit_q, bp_hit_d;
    logic [wordsize-1:0] cnt_q, cnt_d;

    logic brk;
    logic accept;
    logic cmd_moves_state;

    always_comb begin
        cmd_ready_o = (state_q != ST_STEP);
        brk         = bp_en_q & (pc_i == bp_addr_q) & ~skip_q;
        enable_o    = (state_q != ST_HALTED) & ~brk;
        accept      = cmd_valid_i & cmd_ready_o;

        state_d         = state_q;
        bp_en_d         = bp_en_q;
        bp_addr_d       = bp_addr_q;
        run_cnt_d       = run_cnt_q;
        skip_d          = enable_o ? 1'b0 : skip_q;
        bp_hit_d        = bp_hit_q;
        cnt_d           = enable_o ? cnt_q + wordsize'(1) : cnt_q;
        cmd_moves_state = 1'b0;

        if (accept) begin
            case (cmd_op_i)
                OP_RUN: begin
                    state_d         = ST_RUN;
                    skip_d          = 1'b1;
                    bp_hit_d        = 1'b0;
                    cmd_moves_state = 1'b1;
                end
                OP_HALT: begin
                    // a breakpoint landing on the same cycle still gets reported
                    if (brk && state_q != ST_HALTED) begin
                        bp_hit_d = 1'b1;
                    end
                    state_d         = ST_HALTED;
                    cmd_moves_state = 1'b1;
                end
                OP_STEP: begin
                    if (state_q == ST_HALTED) begin
                        state_d         = ST_STEP;
                        skip_d          = 1'b1;
                        bp_hit_d        = 1'b0;
                        cmd_moves_state = 1'b1;
                    end
                end
                OP_RUN_N: begin
                    if (cmd_arg_i != '0) begin
                        state_d         = ST_RUN_N;
                        run_cnt_d       = cmd_arg_i;
                        skip_d          = 1'b1;
                        bp_hit_d        = 1'b0;
                        cmd_moves_state = 1'b1;
                    end
                end
                OP_SET_BP: begin
                    bp_addr_d = cmd_arg_i;
                    bp_en_d   = 1'b1;
                end
                OP_CLR_BP:  bp_en_d = 1'b0;
                OP_CLR_CNT: cnt_d = '0;
                OP_NOP:     ;
                default:    ;
            endcase
        end

        // Non-state commands leave the running sequence untouched.
        if (!cmd_moves_state) begin
            case (state_q)
                ST_STEP: state_d = ST_HALTED;
                ST_RUN: begin
                    if (brk) begin
                        state_d  = ST_HALTED;
                        bp_hit_d = 1'b1;
                    end
                end
                ST_RUN_N: begin
                    if (brk) begin
                        state_d  = ST_HALTED;
                        bp_hit_d = 1'b1;
                    end else begin
                        run_cnt_d = run_cnt_q - wordsize'(1);
                        if (run_cnt_q == wordsize'(1)) begin
                            state_d = ST_HALTED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= ST_HALTED;
            bp_en_q   <= 1'b0;
            bp_addr_q <= '0;
            run_cnt_q <= '0;
            skip_q    <= 1'b0;
            bp_hit_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bp_en_q   <= bp_en_d;
            bp_addr_q <= bp_addr_d;
            run_cnt_q <= run_cnt_d;
            skip_q    <= skip_d;
            bp_hit_q  <= bp_hit_d;
            cnt_q     <= cnt_d;
        end
    end

    assign halted_o      = (state_q == ST_HALTED);
    assign bp_hit_o      = bp_hit_q;
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios then random commands, checked each cycle
// against a behavioural model of the run controller and a toy pc-advancing core.
module tb_mips_run_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i = 3'd0;
    logic [31:0] cmd_arg_i = 32'd0;
    logic [31:0] pc_i = 32'd0;
    logic        enable_o;
    logic        halted_o;
    logic        bp_hit_o;
    logic [31:0] instr_count_o;

    mips_run_ctrl #(.wordsize(32)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_arg_i    (cmd_arg_i),
        .pc_i         (pc_i),
        .enable_o     (enable_o),
        .halted_o     (halted_o),
        .bp_hit_o     (bp_hit_o),
        .instr_count_o(instr_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int en_seen = 0;

    // Behavioural model: plain flags plus a remaining-instruction budget (-1 = unlimited).
    bit          m_valid  = 0;
    bit          m_halted = 1;
    bit          m_single = 0;
    longint      m_left   = 0;
    bit          m_bp_on  = 0;
    int unsigned m_bp     = 0;
    bit          m_skip   = 0;
    bit          m_hit    = 0;
    int unsigned m_count  = 0;
    int unsigned core_pc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_brk(input int unsigned pc);
        return m_bp_on && (pc == m_bp) && !m_skip;
    endfunction

    function automatic bit m_en(input int unsigned pc);
        return !m_halted && (m_single || !m_brk(pc));
    endfunction

    task automatic model_update(input bit v, input logic [2:0] op, input logic [31:0] arg,
                                input bit rst_low, input int unsigned pc);
        bit en, brk, acc, handled;
        if (rst_low) begin
            m_halted = 1; m_single = 0; m_left = 0; m_bp_on = 0; m_bp = 0;
            m_skip = 0; m_hit = 0; m_count = 0; m_valid = 1;
            return;
        end
        en  = m_en(pc);
        brk = m_brk(pc);
        acc = v && !m_single;
        handled = 0;
        if (acc && op == 3'd7) m_count = 0;
        else if (en) m_count = m_count + 1;
        if (en) m_skip = 0;
        if (acc && op == 3'd5) begin m_bp = arg; m_bp_on = 1; end
        if (acc && op == 3'd6) m_bp_on = 0;
        if (acc) begin
            if (op == 3'd1) begin
                m_halted = 0; m_single = 0; m_left = -1; m_skip = 1; m_hit = 0; handled = 1;
            end else if (op == 3'd2) begin
                if (!m_halted && brk) m_hit = 1;
                m_halted = 1; m_single = 0; handled = 1;
            end else if (op == 3'd3 && m_halted) begin
                m_halted = 0; m_single = 1; m_skip = 1; m_hit = 0; handled = 1;
            end else if (op == 3'd4 && arg != 0) begin
                m_halted = 0; m_single = 0; m_left = arg; m_skip = 1; m_hit = 0; handled = 1;
            end
        end
        if (!handled) begin
            if (m_single) begin
                m_halted = 1; m_single = 0;
            end else if (!m_halted) begin
                if (brk) begin
                    m_halted = 1; m_hit = 1;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_halted = 1;
                end
            end
        end
        if (en) core_pc = (core_pc + 4) & 32'h3F;
    endtask

    task automatic cycle(input bit v, input logic [2:0] op, input logic [31:0] arg,
                         input bit rst_low);
        @(negedge clk_i);
        reset_i     = !rst_low;
        cmd_valid_i = v;
        cmd_op_i    = op;
        cmd_arg_i   = arg;
        pc_i        = core_pc;
        #1;
        if (enable_o === 1'b1) en_seen++;
        if (m_valid) begin
            chk("enable", {31'd0, enable_o}, {31'd0, m_en(core_pc)});
            chk("cmd_ready", {31'd0, cmd_ready_o}, {31'd0, !m_single});
            chk("halted", {31'd0, halted_o}, {31'd0, m_halted});
            chk("bp_hit", {31'd0, bp_hit_o}, {31'd0, m_hit});
            chk("instr_count", instr_count_o, m_count);
        end
        @(posedge clk_i);
        #1;
        model_update(v, op, arg, rst_low, core_pc);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
        cycle(1'b1, op, arg, 1'b0);
    endtask

    initial begin
        bit          rv, rr;
        logic [2:0]  rop;
        logic [31:0] rarg;

        cycle(1'b0, 3'd0, 32'd0, 1'b1);
        cycle(1'b0, 3'd0, 32'd0, 1'b1);
        idle(10);
        chk("idle_enable", {31'd0, enable_o}, 32'd0);
        chk("idle_halted", {31'd0, halted_o}, 32'd1);
        chk("idle_count", instr_count_o, 32'd0);
        chk("idle_ready", {31'd0, cmd_ready_o}, 32'd1);

        core_pc = 0;
        en_seen = 0;
        cmd(3'd3, 32'd0);
        idle(3);
        chk("step_en_cycles", en_seen, 32'd1);
        chk("step_count", instr_count_o, 32'd1);
        chk("step_halted", {31'd0, halted_o}, 32'd1);

        cmd(3'd7, 32'd0);
        cmd(3'd5, 32'h10);
        core_pc = 0;
        cmd(3'd1, 32'd0);
        idle(6);
        chk("bp_count", instr_count_o, 32'd4);
        chk("bp_hit_set", {31'd0, bp_hit_o}, 32'd1);
        chk("bp_halted", {31'd0, halted_o}, 32'd1);
        cmd(3'd1, 32'd0);
        idle(1);
        chk("resume_count", instr_count_o, 32'd5);
        chk("resume_bp_hit", {31'd0, bp_hit_o}, 32'd0);
        idle(1);
        cmd(3'd2, 32'd0);
        idle(1);

        cmd(3'd6, 32'd0);
        cmd(3'd7, 32'd0);
        en_seen = 0;
        cmd(3'd4, 32'd5);
        idle(8);
        chk("runn_en_cycles", en_seen, 32'd5);
        chk("runn_count", instr_count_o, 32'd5);
        chk("runn_halted", {31'd0, halted_o}, 32'd1);
        cmd(3'd4, 32'd0);
        idle(3);
        chk("runn0_count", instr_count_o, 32'd5);
        chk("runn0_halted", {31'd0, halted_o}, 32'd1);

        cmd(3'd7, 32'd0);
        en_seen = 0;
        cmd(3'd1, 32'd0);
        idle(2);
        cmd(3'd2, 32'd0);
        idle(2);
        chk("halt3_en_cycles", en_seen, 32'd3);
        chk("halt3_count", instr_count_o, 32'd3);
        chk("halt3_halted", {31'd0, halted_o}, 32'd1);

        cmd(3'd5, 32'h30);
        core_pc = 32'h24;
        cmd(3'd1, 32'd0);
        idle(2);
        cycle(1'b0, 3'd0, 32'd0, 1'b1);
        idle(1);
        chk("rst_enable", {31'd0, enable_o}, 32'd0);
        chk("rst_halted", {31'd0, halted_o}, 32'd1);
        chk("rst_count", instr_count_o, 32'd0);
        core_pc = 32'h2C;
        en_seen = 0;
        cmd(3'd1, 32'd0);
        idle(3);
        chk("rst_bp_cleared", en_seen, 32'd3);
        cmd(3'd2, 32'd0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            rr   = ($urandom_range(0, 199) == 0);
            rv   = ($urandom_range(0, 9) < 4);
            rop  = 3'($urandom_range(0, 7));
            if (rop == 3'd4) rarg = $urandom_range(0, 8);
            else if (rop == 3'd5) rarg = $urandom_range(0, 15) * 4;
            else rarg = $urandom;
            if ($urandom_range(0, 49) == 0) core_pc = $urandom_range(0, 15) * 4;
            cycle(rv, rop, rarg, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
